// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - ID-stage branch resolution with bimodal BHT and statistics
// Decodes BOp against comparator flags, updates 2-bit counters, and raises mispredict/redirect.
module branch_predict_resolve #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         STAT_BITS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic [31:0] id_pc,
  input  logic [3:0]  BOp,
  input  logic        More,
  input  logic        Zero,
  input  logic        Less,
  input  logic        id_pred,
  output logic        actual_taken,
  output logic        mispredict,
  output logic        redirect_to_target,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int                   ENTRIES  = 1 << INDEX_BITS;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
  localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};

  logic [1:0]           r_bht [0:ENTRIES-1];
  logic [STAT_BITS-1:0] r_branch_cnt;
  logic [STAT_BITS-1:0] r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [INDEX_BITS-1:0] w_id_idx;
  logic                  w_is_branch;
  logic                  w_taken;
  logic                  w_resolve;
  logic [1:0]            w_bht_cur;
  logic [1:0]            w_bht_nxt;
  logic                  w_unused;

  assign w_if_idx = if_pc[INDEX_BITS+1:2];
  assign w_id_idx = id_pc[INDEX_BITS+1:2];
  assign w_unused = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0], id_pc[31:INDEX_BITS+2], id_pc[1:0]};

  always_comb begin
    w_is_branch = 1'b1;
    w_taken     = 1'b0;
    case (BOp)
      4'b0001: w_taken = Zero;
      4'b0010: w_taken = ~Zero;
      4'b0011: w_taken = Zero | Less;
      4'b0100: w_taken = More;
      4'b0101: w_taken = Less;
      4'b0110: w_taken = Zero | More;
      4'b0111: w_taken = Zero | More;
      default: w_is_branch = 1'b0;
    endcase
  end

  assign actual_taken       = w_is_branch & w_taken;
  assign w_resolve          = id_valid & ~id_stall & w_is_branch;
  assign mispredict         = w_resolve & (actual_taken != id_pred);
  assign redirect_to_target = mispredict & actual_taken;

  // Read port sees only registered table state; no same-cycle bypass.
  assign pred_taken = r_bht[w_if_idx][1];

  always_comb begin
    w_bht_cur = r_bht[w_id_idx];
    w_bht_nxt = w_bht_cur;
    if (actual_taken) begin
      if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'b01;
    end else begin
      if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CNT_INIT;
    end else if (w_resolve) begin
      r_bht[w_id_idx] <= w_bht_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && r_branch_cnt != STAT_MAX) r_branch_cnt <= r_branch_cnt + STAT_ONE;
      if (mispredict && r_mispred_cnt != STAT_MAX) r_mispred_cnt <= r_mispred_cnt + STAT_ONE;
    end
  end

  assign branch_cnt  = 32'(r_branch_cnt);
  assign mispred_cnt = 32'(r_mispred_cnt);

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - directed self-checking bench for branch_predict_resolve
// A second instance with 3-bit statistics exercises counter saturation.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        id_valid, id_stall;
  logic [31:0] id_pc;
  logic [3:0]  BOp;
  logic        More, Zero, Less, id_pred;
  logic        pred_taken, actual_taken, mispredict, redirect_to_target;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        unused_s_pred, unused_s_act, unused_s_misp, unused_s_redir;
  logic [31:0] s_branch_cnt, s_mispred_cnt;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_tab [1:7];

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .BOp(BOp),
    .More(More), .Zero(Zero), .Less(Less), .id_pred(id_pred),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .redirect_to_target(redirect_to_target),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predict_resolve #(.STAT_BITS(3)) dut_s (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(unused_s_pred),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .BOp(BOp),
    .More(More), .Zero(Zero), .Less(Less), .id_pred(id_pred),
    .actual_taken(unused_s_act), .mispredict(unused_s_misp),
    .redirect_to_target(unused_s_redir),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic [3:0] op,
                       input logic m, input logic z, input logic l, input logic p);
    id_valid = v; id_stall = s; id_pc = pc; BOp = op;
    More = m; Zero = z; Less = l; id_pred = p;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_tab[1] = 3'b010; exp_tab[2] = 3'b101; exp_tab[3] = 3'b011; exp_tab[4] = 3'b100;
    exp_tab[5] = 3'b001; exp_tab[6] = 3'b110; exp_tab[7] = 3'b110;

    reset = 1'b1; if_pc = 32'h0000_3000;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pred", {31'b0, pred_taken}, 32'd0);
    chk("reset_branch_cnt", branch_cnt, 32'd0);
    chk("reset_mispred_cnt", mispred_cnt, 32'd0);
    #11 reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if_pc = i << 2;
      #1 chk("reset_entry_pred", {31'b0, pred_taken}, 32'd0);
    end

    // beq taken at index 1, first with wrong prediction
    tick;
    if_pc = 32'h0000_3004;
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_actual", {31'b0, actual_taken}, 32'd1);
    chk("beq_mispredict_c1", {31'b0, mispredict}, 32'd1);
    chk("beq_redirect_c1", {31'b0, redirect_to_target}, 32'd1);
    chk("beq_pred_before", {31'b0, pred_taken}, 32'd0);
    tick;
    chk("beq_pred_after1", {31'b0, pred_taken}, 32'd1);
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("beq_mispredict_c2", {31'b0, mispredict}, 32'd0);
    tick;
    tick;
    chk("beq_branch_cnt", branch_cnt, 32'd3);
    chk("beq_mispred_cnt", mispred_cnt, 32'd1);
    // One not-taken from 11 must leave the prediction at 1
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("nt_actual", {31'b0, actual_taken}, 32'd0);
    chk("nt_mispredict", {31'b0, mispredict}, 32'd1);
    chk("nt_redirect", {31'b0, redirect_to_target}, 32'd0);
    tick;
    chk("nt_pred_sat", {31'b0, pred_taken}, 32'd1);
    chk("nt_branch_cnt", branch_cnt, 32'd4);
    chk("nt_mispred_cnt", mispred_cnt, 32'd2);

    // Full decode table, no updates
    for (int b = 1; b <= 7; b++) begin
      for (int f = 0; f < 3; f++) begin
        logic [2:0] fl;
        logic [2:0] row;
        fl = 3'b100 >> f;
        row = exp_tab[b];
        drive(1'b0, 1'b0, 32'h0000_3004, 4'(b), fl[2], fl[1], fl[0], 1'b0);
        chk($sformatf("decode_bop%0d_f%0d", b, f), {31'b0, actual_taken}, {31'b0, row[2-f]});
        chk("decode_no_mispredict", {31'b0, mispredict}, 32'd0);
      end
    end
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bop0_actual", {31'b0, actual_taken}, 32'd0);
    chk("bop0_mispredict", {31'b0, mispredict}, 32'd0);
    tick;
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bop8_actual", {31'b0, actual_taken}, 32'd0);
    chk("bop8_mispredict", {31'b0, mispredict}, 32'd0);
    tick;
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    tick;
    chk("nonbranch_branch_cnt", branch_cnt, 32'd4);
    chk("nonbranch_mispred_cnt", mispred_cnt, 32'd2);

    // Stall blocks resolution at index 2
    if_pc = 32'h0000_3008;
    drive(1'b1, 1'b1, 32'h0000_3008, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stall_mispredict", {31'b0, mispredict}, 32'd0);
    chk("stall_redirect", {31'b0, redirect_to_target}, 32'd0);
    tick;
    chk("stall_pred", {31'b0, pred_taken}, 32'd0);
    chk("stall_branch_cnt", branch_cnt, 32'd4);
    chk("stall_mispred_cnt", mispred_cnt, 32'd2);
    drive(1'b1, 1'b0, 32'h0000_3008, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("unstall_mispredict", {31'b0, mispredict}, 32'd1);
    chk("unstall_redirect", {31'b0, redirect_to_target}, 32'd1);
    tick;
    drive(1'b0, 1'b0, 32'h0000_3008, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unstall_pred", {31'b0, pred_taken}, 32'd1);
    chk("unstall_branch_cnt", branch_cnt, 32'd5);
    chk("unstall_mispred_cnt", mispred_cnt, 32'd3);

    // Same-cycle read/write at index 5
    if_pc = 32'h0000_0014;
    drive(1'b1, 1'b0, 32'h0000_0014, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("idx5_pred_old", {31'b0, pred_taken}, 32'd0);
    tick;
    chk("idx5_pred_new", {31'b0, pred_taken}, 32'd1);
    drive(1'b0, 1'b0, 32'h0000_0014, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bring index 1 back to 11, then reset mid-cycle
    if_pc = 32'h0000_3004;
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    tick;
    drive(1'b0, 1'b0, 32'h0000_3004, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prereset_branch_cnt", branch_cnt, 32'd7);
    chk("prereset_mispred_cnt", mispred_cnt, 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("midreset_pred_idx1", {31'b0, pred_taken}, 32'd0);
    chk("midreset_branch_cnt", branch_cnt, 32'd0);
    chk("midreset_mispred_cnt", mispred_cnt, 32'd0);
    if_pc = 32'h0000_0014;
    #1 chk("midreset_pred_idx5", {31'b0, pred_taken}, 32'd0);
    #1 reset = 1'b0;
    if_pc = 32'h0000_3004;
    tick;
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("postreset_mispredict", {31'b0, mispredict}, 32'd1);
    tick;
    chk("postreset_pred_10", {31'b0, pred_taken}, 32'd1);
    drive(1'b1, 1'b0, 32'h0000_3004, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    chk("postreset_pred_01", {31'b0, pred_taken}, 32'd0);
    chk("postreset_branch_cnt", branch_cnt, 32'd2);
    chk("postreset_mispred_cnt", mispred_cnt, 32'd1);

    // Saturation in the 3-bit statistics instance
    drive(1'b1, 1'b0, 32'h0000_0040, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick;
    chk("sat_s_branch_at_max", s_branch_cnt, 32'd7);
    chk("sat_s_mispred_6", s_mispred_cnt, 32'd6);
    for (int k = 0; k < 5; k++) tick;
    drive(1'b0, 1'b0, 32'h0000_0040, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_s_branch_hold", s_branch_cnt, 32'd7);
    chk("sat_s_mispred_hold", s_mispred_cnt, 32'd7);
    chk("sat_full_branch_cnt", branch_cnt, 32'd12);
    chk("sat_full_mispred_cnt", mispred_cnt, 32'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Consumer end of the ID-stage branch comparator: takes its More/Zero/Less flags plus the branch opcode BOp and resolves each branch as taken or not-taken.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters.
- The IF stage reads the table for a prediction. The ID stage writes the resolved outcome back and raises mispredict/redirect to the fetch unit.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries (64 entries); index = pc[INDEX_BITS+1:2]
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- if_pc  input  32  PC of the instruction in IF
- pred_taken  output  1  prediction for if_pc; combinational from table state
- id_valid  input  1  ID holds a valid instruction
- id_stall  input  1  ID is stalled this cycle; no update, no redirect
- id_pc  input  32  PC of the instruction in ID
- BOp  input  4  branch opcode from decode
- More  input  1  comparator: A > B (signed)
- Zero  input  1  comparator: A == B
- Less  input  1  comparator: A < B (signed)
- id_pred  input  1  prediction carried down the pipe with the ID instruction
- actual_taken  output  1  resolved direction (combinational)
- mispredict  output  1  flush/redirect request (combinational)
- redirect_to_target  output  1  1: refetch at branch target; 0: refetch at fall-through (id_pc+8)
- branch_cnt  output  32  number of resolved branches
- mispred_cnt  output  32  number of mispredicted branches

Behaviour:
- BOp decode; is_branch = BOp in 0001..0111:
  - 0000: not a branch
  - 0001 beq: taken = Zero
  - 0010 bne: taken = ~Zero
  - 0011 blez: taken = Zero|Less
  - 0100 bgtz: taken = More
  - 0101 bltz: taken = Less
  - 0110 bgez: taken = Zero|More
  - 0111 bgezal: taken = Zero|More
  - 1000-1111: not a branch
- actual_taken = is_branch & taken; forced 0 when is_branch=0.
- resolve = id_valid & ~id_stall & is_branch.
- mispredict = resolve & (actual_taken != id_pred). redirect_to_target = mispredict & actual_taken.
- Prediction: pred_taken = bht[if_pc[INDEX_BITS+1:2]][1]. No registered latency. There is no write-to-read bypass: a same-cycle update to the same index is seen by the read in the next cycle.
- BHT update on the posedge where resolve=1, at index id_pc[INDEX_BITS+1:2]:
  - taken: 00->01->10->11, holds at 11
  - not-taken: 11->10->01->00, holds at 00
  - no other entry changes
- Statistics, updated on the same edge:
  - branch_cnt +1 on resolve
  - mispred_cnt +1 on mispredict
  - both saturate at 32'hFFFFFFFF, no wrap
- Reset (async, any time, including mid-stream):
  - every BHT entry = CNT_INIT
  - branch_cnt = 0, mispred_cnt = 0
  - pred_taken follows the reset table immediately (0 with default CNT_INIT)
  - combinational outputs follow their inputs; no state is retained after reset is released
- id_stall=1 or id_valid=0: no table or counter change, and mispredict = 0, even when the flags would mismatch.
- Flags not exactly one-hot is an upstream illegal case. Outputs still follow the equations above; the bench does not check it.
- Aliasing: PCs that share index bits share one counter. This is intended; there is no tag.

Test Plan:
- Reset, then if_pc=0x00003000 -> pred_taken=0; branch_cnt=0; mispred_cnt=0; every index reads 0.
- id_pc=0x00003004, BOp=0001, Zero=1, id_pred=0, valid, 3 cycles -> cycle 1: mispredict=1, redirect_to_target=1. Entry 1 goes 01->10->11->11; pred_taken at if_pc=0x3004 becomes 1 after the first edge. Cycles 2-3: with id_pred=1, mispredict=0. Final counts: branch_cnt=3, mispred_cnt=1.
- All 7 BOp codes against each one-hot flag (21 cases) with id_pred=0 -> actual_taken per the table, e.g. blez with More=1 -> 0, bgtz with More=1 -> 1. BOp=0000 and 1000 -> actual_taken=0, mispredict=0, counters unchanged.
- id_stall=1 with bne, Zero=0, id_pred=0 -> mispredict=0, BHT and counters unchanged. Release the stall -> mispredict=1, redirect_to_target=1, counters +1.
- Update index 5 while if_pc hits index 5 in the same cycle -> pred_taken shows the old value that cycle and the new value the next. Saturation: force mispred_cnt to 32'hFFFFFFFF via a long run, or run 2^32 steps in a reduced-width build -> it stays at max.
- Assert reset mid-run, while an entry is at 11 and the counters are nonzero -> the entry returns to 01 and the counters to 0 without waiting for a clock edge. The first branch after release updates from 01.
